// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: access sizes, FSM states,
// byte-enable generation, store-lane steering and alignment checking.
package dmem_responder_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    BYTE_S = 3'd0,
    BYTE_U = 3'd1,
    HALF_S = 3'd2,
    HALF_U = 3'd3,
    WORD   = 3'd4
  } data_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Signed and unsigned sizes share lane enables; sign extension lives in the MEM stage.
  function automatic logic [3:0] dmem_byte_en(input data_size_e size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      BYTE_S, BYTE_U: be = 4'b0001 << addr_lo;
      HALF_S, HALF_U: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:        be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] dmem_lane_data(input data_size_e size,
                                                           input logic [DATA_WIDTH-1:0] wdata);
    logic [DATA_WIDTH-1:0] lanes;
    case (size)
      BYTE_S, BYTE_U: lanes = {4{wdata[7:0]}};
      HALF_S, HALF_U: lanes = {2{wdata[15:0]}};
      default:        lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic dmem_misaligned(input data_size_e size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      HALF_S, HALF_U: mis = addr_lo[0];
      WORD:           mis = (addr_lo != 2'b00);
      default:        mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Pipeline-to-data-memory request/response bundle; master is the MEM stage, slave the responder.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic                  req_i;
  logic                  we_i;
  data_size_e            size_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  ready_o;
  logic                  err_o;
  logic                  busy_o;

  modport master (
    output req_i, we_i, size_i, addr_i, wdata_i,
    input  rdata_o, ready_o, err_o, busy_o
  );

  modport slave (
    input  req_i, we_i, size_i, addr_i, wdata_i,
    output rdata_o, ready_o, err_o, busy_o
  );

endinterface

// File: rtl/dmem_ram_array.sv
// Single-port word RAM built from four byte-wide banks: byte-masked synchronous write,
// registered full-word read with a clear used to return zero on errored accesses.
module dmem_ram_array #(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [3:0]       i_be,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  input  logic             i_re,
  input  logic             i_clr,
  output logic [31:0]      o_rdata
);

  logic [7:0]  r_bank [4][DEPTH_WORDS];
  logic [31:0] r_rdata;

  for (genvar b = 0; b < 4; b++) begin : g_lane
    always_ff @(posedge clk) begin
      if (i_we && i_be[b]) begin
        r_bank[b][i_idx] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Read register holds its value between accesses so the bus sees a stable word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_clr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= {r_bank[3][i_idx], r_bank[2][i_idx], r_bank[1][i_idx], r_bank[0][i_idx]};
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures one load/store, waits WAIT_CYCLES, accesses the RAM and
// pulses ready_o. Define DMEM_RANGE_CHECK_EN to flag addresses beyond DEPTH_WORDS as errors.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0]  CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_e           r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  data_size_e            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_ready;
  logic                  r_err;
  logic                  r_busy;

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_sel_we;
  data_size_e            w_sel_size;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_misalign;
  logic                  w_range_err;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  // With no wait states the RAM is hit on the accepting edge, before capture lands.
  assign w_accept    = (r_state == IDLE) && bus.req_i;
  assign w_commit    = (w_accept && NO_WAIT) || ((r_state == WAIT) && (r_cnt == 4'd0));
  assign w_sel_we    = (r_state == IDLE) ? bus.we_i    : r_we;
  assign w_sel_size  = (r_state == IDLE) ? bus.size_i  : r_size;
  assign w_sel_addr  = (r_state == IDLE) ? bus.addr_i  : r_addr;
  assign w_sel_wdata = (r_state == IDLE) ? bus.wdata_i : r_wdata;

  assign w_misalign = dmem_misaligned(w_sel_size, w_sel_addr[1:0]);

`ifdef DMEM_RANGE_CHECK_EN
  assign w_range_err = |w_sel_addr[ADDR_WIDTH-1:2+IDX_W];
`else
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^w_sel_addr[ADDR_WIDTH-1:2+IDX_W];
  assign w_range_err      = 1'b0;
`endif

  assign w_err = w_misalign || w_range_err;

  dmem_ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_commit && w_sel_we && !w_err),
    .i_be    (dmem_byte_en(w_sel_size, w_sel_addr[1:0])),
    .i_idx   (w_sel_addr[2 +: IDX_W]),
    .i_wdata (dmem_lane_data(w_sel_size, w_sel_wdata)),
    .i_re    (w_commit && !w_sel_we && !w_err),
    .i_clr   (w_commit && w_err),
    .o_rdata (w_ram_rdata)
  );

  // Request sequencer; ready/err/busy are registered so they follow the state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_size  <= WORD;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_i) begin
            r_we    <= bus.we_i;
            r_size  <= bus.size_i;
            r_addr  <= bus.addr_i;
            r_wdata <= bus.wdata_i;
            r_busy  <= 1'b1;
            if (NO_WAIT) begin
              r_state <= RESP;
              r_ready <= 1'b1;
              r_err   <= w_err;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_err   <= w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdata_o = w_ram_rdata;
  assign bus.ready_o = r_ready;
  assign bus.err_o   = r_err;
  assign bus.busy_o  = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with no wait states, one with three.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  typedef struct {
    string       tag;
    bit          chk_rd;
    logic [31:0] rd;
    bit          err;
  } sb_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst3;

  int n_checks = 0;
  int n_fail   = 0;

  sb_t q0[$];
  sb_t q3[$];
  logic [31:0] mem_m [int unsigned];

  dmem_responder_if bus0();
  dmem_responder_if bus3();

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic ready_of(input int d);
    return (d == 0) ? bus0.ready_o : bus3.ready_o;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? bus0.busy_o : bus3.busy_o;
  endfunction

  task automatic drive(input int d, input bit req, input bit we, input data_size_e sz,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      bus0.req_i = req; bus0.we_i = we; bus0.size_i = sz; bus0.addr_i = a; bus0.wdata_i = wd;
    end else begin
      bus3.req_i = req; bus3.we_i = we; bus3.size_i = sz; bus3.addr_i = a; bus3.wdata_i = wd;
    end
  endtask

  // Reference memory: lane updates by part-select, errors from the address rules directly.
  function automatic void model(input int d, input bit we, input data_size_e sz,
                                input logic [31:0] a, input logic [31:0] wd,
                                output bit e, output logic [31:0] rd);
    int unsigned key;
    logic [31:0] w;
    key = ((d == 0) ? 32'h0 : 32'h1000) | ((a >> 2) & 32'h3FF);
    e = ((sz == HALF_S || sz == HALF_U) && a[0]) || (sz == WORD && a[1:0] != 2'b00);
`ifdef DMEM_RANGE_CHECK_EN
    if ((a >> 2) >= 32'd1024) e = 1'b1;
`endif
    w  = mem_m.exists(key) ? mem_m[key] : 32'h0;
    rd = e ? 32'h0 : w;
    if (we && !e) begin
      case (sz)
        BYTE_S, BYTE_U: w[8*a[1:0] +: 8]  = wd[7:0];
        HALF_S, HALF_U: w[16*a[1] +: 16]  = wd[15:0];
        default:        w                 = wd;
      endcase
      mem_m[key] = w;
    end
  endfunction

  task automatic expect_resp(input int d, input bit we, input data_size_e sz,
                             input logic [31:0] a, input logic [31:0] wd, input string tag);
    sb_t s;
    bit e;
    logic [31:0] rd;
    model(d, we, sz, a, wd, e, rd);
    s.tag = tag; s.chk_rd = !we || e; s.rd = rd; s.err = e;
    if (d == 0) q0.push_back(s); else q3.push_back(s);
  endtask

  task automatic do_access(input int d, input bit we, input data_size_e sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           input string tag, input bit perturb);
    int k;
    int lat;
    lat = (d == 0) ? 1 : 4;
    expect_resp(d, we, sz, a, wd, tag);
    @(negedge clk);
    drive(d, 1'b1, we, sz, a, wd);
    check_eq({tag, "_idle_busy"}, 32'(busy_of(d)), 32'd0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (perturb && k == 1) drive(d, 1'b1, ~we, BYTE_U, a ^ 32'h4, ~wd);
      check_eq({tag, "_busy"}, 32'(busy_of(d)), 32'd1);
    end while (!ready_of(d) && k < 20);
    check_eq({tag, "_lat"}, 32'(k), 32'(lat));
    drive(d, 1'b0, 1'b0, WORD, 32'h0, 32'h0);
  endtask

  always @(negedge clk) begin : mon0
    sb_t s;
    if (bus0.ready_o) begin
      if (q0.size() == 0) check_eq("d0_spurious_ready", 32'(bus0.ready_o), 32'd0);
      else begin
        s = q0.pop_front();
        check_eq({s.tag, "_err"}, 32'(bus0.err_o), 32'(s.err));
        if (s.chk_rd) check_eq({s.tag, "_rdata"}, bus0.rdata_o, s.rd);
      end
    end else if (bus0.err_o) begin
      check_eq("d0_err_outside_resp", 32'(bus0.err_o), 32'd0);
    end
  end

  always @(negedge clk) begin : mon3
    sb_t s;
    if (bus3.ready_o) begin
      if (q3.size() == 0) check_eq("d3_spurious_ready", 32'(bus3.ready_o), 32'd0);
      else begin
        s = q3.pop_front();
        check_eq({s.tag, "_err"}, 32'(bus3.err_o), 32'(s.err));
        if (s.chk_rd) check_eq({s.tag, "_rdata"}, bus3.rdata_o, s.rd);
      end
    end else if (bus3.err_o) begin
      check_eq("d3_err_outside_resp", 32'(bus3.err_o), 32'd0);
    end
  end

  initial begin
    int k;
    int first;
    int second;
    rst0 = 1'b1;
    rst3 = 1'b1;
    drive(0, 1'b0, 1'b0, WORD, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, WORD, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check_eq("rst_rdata0", bus0.rdata_o, 32'h0);
    check_eq("rst_ready0", 32'(bus0.ready_o), 32'd0);
    check_eq("rst_err0", 32'(bus0.err_o), 32'd0);
    check_eq("rst_busy0", 32'(bus0.busy_o), 32'd0);
    check_eq("rst_busy3", 32'(bus3.busy_o), 32'd0);
    rst0 = 1'b0;
    rst3 = 1'b0;

    do_access(0, 1'b1, WORD,   32'h10, 32'hDEADBEEF, "st_word10", 1'b0);
    do_access(0, 1'b0, WORD,   32'h10, 32'h0,        "ld_word10", 1'b0);
    do_access(0, 1'b1, WORD,   32'h20, 32'h11223344, "st_word20", 1'b0);
    do_access(0, 1'b1, BYTE_U, 32'h21, 32'hFFFFFFA5, "st_byte21", 1'b0);
    do_access(0, 1'b0, WORD,   32'h20, 32'h0,        "ld_after_byte", 1'b0);
    do_access(0, 1'b1, HALF_S, 32'h22, 32'h0000BEEF, "st_half22", 1'b0);
    do_access(0, 1'b0, WORD,   32'h20, 32'h0,        "ld_after_half", 1'b0);
    do_access(0, 1'b1, BYTE_S, 32'h13, 32'h0000007E, "st_byte13", 1'b0);
    do_access(0, 1'b0, BYTE_S, 32'h12, 32'h0,        "ld_byte_word10", 1'b0);
    do_access(0, 1'b1, WORD,   32'h30, 32'h30303030, "st_word30", 1'b0);
    do_access(0, 1'b1, HALF_U, 32'h31, 32'h0000FFFF, "st_half31_mis", 1'b0);
    do_access(0, 1'b1, WORD,   32'h32, 32'hFFFFFFFF, "st_word32_mis", 1'b0);
    do_access(0, 1'b0, WORD,   32'h30, 32'h0,        "ld_word30", 1'b0);
    do_access(0, 1'b0, HALF_U, 32'h33, 32'h0,        "ld_half33_mis", 1'b0);
    do_access(0, 1'b1, WORD,   32'h04, 32'h0BADF00D, "st_word04", 1'b0);
    do_access(0, 1'b0, WORD,   32'h1004, 32'h0,      "ld_word1004", 1'b0);

    do_access(1, 1'b1, WORD, 32'h54, 32'h54545454, "w3_st54", 1'b0);
    do_access(1, 1'b1, WORD, 32'h50, 32'hCAFEF00D, "w3_st50_pert", 1'b1);
    do_access(1, 1'b0, WORD, 32'h50, 32'h0,        "w3_ld50", 1'b0);
    do_access(1, 1'b0, WORD, 32'h54, 32'h0,        "w3_ld54", 1'b0);

    // Two loads with req held high across the response.
    expect_resp(1, 1'b0, WORD, 32'h50, 32'h0, "b2b_a");
    expect_resp(1, 1'b0, WORD, 32'h54, 32'h0, "b2b_b");
    @(negedge clk);
    drive(1, 1'b1, 1'b0, WORD, 32'h50, 32'h0);
    first = -1;
    second = -1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (bus3.ready_o) begin
        if (first < 0) begin
          first = k;
          drive(1, 1'b1, 1'b0, WORD, 32'h54, 32'h0);
        end else second = k;
      end
    end while (second < 0 && k < 30);
    check_eq("b2b_first_lat", 32'(first), 32'd4);
    check_eq("b2b_spacing", 32'(second - first), 32'd5);
    drive(1, 1'b0, 1'b0, WORD, 32'h0, 32'h0);

    // Reset while a store sits in WAIT: nothing commits, no response.
    do_access(1, 1'b1, WORD, 32'h40, 32'h11111111, "pre_rst_st40", 1'b0);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, WORD, 32'h40, 32'h99999999);
    @(negedge clk);
    check_eq("mid_wait_busy", 32'(bus3.busy_o), 32'd1);
    rst3 = 1'b1;
    drive(1, 1'b0, 1'b0, WORD, 32'h0, 32'h0);
    #1;
    check_eq("rst_mid_busy", 32'(bus3.busy_o), 32'd0);
    check_eq("rst_mid_ready", 32'(bus3.ready_o), 32'd0);
    check_eq("rst_mid_rdata", bus3.rdata_o, 32'h0);
    @(negedge clk);
    rst3 = 1'b0;
    do_access(1, 1'b0, WORD, 32'h40, 32'h0, "post_rst_ld40", 1'b0);

    repeat (3) @(negedge clk);
    check_eq("q0_drained", 32'(q0.size()), 32'd0);
    check_eq("q3_drained", 32'(q3.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
